memop_arbiter: RTL and testbench
================================

// Module: memop_arbiter
//
// PURPOSE
//  Shares one ZipCPU memory-op unit (the stb/op/addr/busy/rdbusy/valid/done/err
//  interface) between two requesters: A (CPU pipeline) and B (debug/DMA port).
//  - Grants the unit to one requester at a time and muxes its request down.
//  - Routes done/valid/err/wreg/result back to the owner only.
//  - Keeps the grant across LOCK sequences.
//  - Upholds the unit's rules: no stb while busy, no stb in the cycle of or
//    after an err, and request fields held stable while stalled.
//
// PARAMETERS
//  AW         32  address width
//  DW         32  data/result width
//  F_LGDEPTH   4  width of the outstanding-op counter
//  OPT_MAXDEPTH 1  maximum ops in flight downstream (1..2**F_LGDEPTH-1)
//
// PORTS
//  i_clk          in   1   clock
//  i_reset_n      in   1   asynchronous, active-low reset
//  i_{a,b}_stb    in   1   request strobe
//  i_{a,b}_lock   in   1   locked-sequence request
//  i_{a,b}_op     in   3   memory op (op[0]=1 for a store; op[2:1]!=0)
//  i_{a,b}_addr   in   AW  address
//  i_{a,b}_data   in   DW  store data
//  i_{a,b}_oreg   in   5   destination register tag
//  o_{a,b}_stall  out  1   request not accepted this cycle
//  o_{a,b}_busy / _rdbusy / _valid / _done / _err   out  1  owner-gated status
//  o_{a,b}_wreg   out  5   returned register tag
//  o_{a,b}_result out  DW  load data
//  o_m_stb / _lock / _op / _addr / _data / _oreg    out  to memory unit
//  i_m_busy / _rdbusy / _valid / _done / _err / _wreg / _result  in  from unit
//
// BEHAVIOUR
//  - Reset (i_reset_n=0, async): grant=IDLE, lock_held=0, outstanding=0.
//    All o_* are 0, except o_{a,b}_stall=1.
//  - States: IDLE, OWN_A, OWN_B (2-bit registered).
//    - IDLE: pick a requester with stb=1 and move to OWN_x on the next clock.
//      No stb is forwarded in the pick cycle, so arbitration costs 1 cycle.
//    - OWN_x -> IDLE only when all of these hold: outstanding==0, !i_m_busy,
//      !lock_held, and the owner's stb is 0.
//  - Forwarding is combinational.
//    - o_m_stb = owner_stb & !i_m_busy & !i_m_err & !err_q
//      & (outstanding < OPT_MAXDEPTH).
//    - o_m_* fields are the owner's fields; they are zero when IDLE.
//    - o_x_stall = !(grant==OWN_x) | i_m_busy | i_m_err | err_q
//      | outstanding==OPT_MAXDEPTH.
//  - Accept = o_m_stb. An accepted op adds 1 to outstanding and each i_m_done
//    subtracts 1; both in one cycle leave it unchanged.
//  - i_m_err: outstanding<=0 and err_q<=1 for one cycle, which blocks stb.
//    lock_held<=0. The err goes to the owner only.
//  - lock_held is set on accept with lock=1 and cleared on accept with lock=0
//    or on err. While set, the other requester is never granted.
//  - Response routing uses the grant register, which cannot change while ops
//    are in flight. valid/done/err/wreg/result go to the owner. The
//    non-owner's outputs are 0.
//  - o_x_busy and o_x_rdbusy mirror i_m_busy/i_m_rdbusy for the owner only.
//  - Simultaneous stb from A and B in IDLE: see CONFIGURATION.
//  - outstanding never exceeds OPT_MAXDEPTH; the counter saturates and the
//    bench checks the bound.
//
// CONFIGURATION
//  MEMARB_ROUND_ROBIN_EN
//    - defined: on a tie in IDLE, grant the requester not served last
//      (last_owner flop, reset to B, so A wins the first tie).
//    - undefined: fixed priority, A always wins ties; no last_owner flop.
//
// STRUCTURE
//  - Package memarb_pkg:
//    - grant_t enum {IDLE, OWN_A, OWN_B}
//    - OP_STORE_BIT=0
//    - REGW=5
//  - Sub-module memarb_pick: combinational tie-break (stb_a, stb_b,
//    last_owner -> pick). Its round-robin path is under MEMARB_ROUND_ROBIN_EN.
//  - Top level holds the grant FSM, outstanding counter, lock_held, err_q
//    and the muxes.
//
// TESTING
//  1. A-only load: A stb op=3'b100, addr=0x100.
//     -> grant OWN_A next cycle; o_m_stb next cycle; A sees valid+done with
//        result=0xDEADBEEF; B's outputs stay 0.
//  2. A and B stb in the same cycle, from IDLE.
//     -> without macro: A, then A again on a repeat tie.
//     -> with MEMARB_ROUND_ROBIN_EN: A, then B.
//  3. B lock seq: 3 stores at 0x10,0x14,0x18 with lock=1,1,0 while A holds stb.
//     -> A stalled until B's third done; then grant goes IDLE -> OWN_A.
//  4. i_m_err on A's store at 0x20.
//     -> A err=1, no o_m_stb that cycle or the next, outstanding=0,
//        lock_held=0.
//  5. OPT_MAXDEPTH=2: A issues 3 back-to-back loads.
//     -> third stalls until the first done; outstanding peaks at 2.
//  6. Reset with 1 op in flight (i_reset_n low mid-op).
//     -> all outputs 0 immediately, stalls=1, grant IDLE; no stray
//        done is routed after release.

Source files
------------

// File: rtl/memarb_pkg.sv
// ============================================================================
// memarb_pkg : shared types and constants for the memory-op arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

package memarb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } grant_t;

    localparam int OP_STORE_BIT = 0;
    localparam int REGW         = 5;

endpackage

`default_nettype wire

// File: rtl/memop_arbiter_if.sv
// ============================================================================
// memop_arbiter_if : requester A/B and memory-unit signal bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface memop_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    // Requester A
    logic                        a_stb, a_lock;
    logic [2:0]                  a_op;
    logic [AW-1:0]               a_addr;
    logic [DW-1:0]               a_data;
    logic [memarb_pkg::REGW-1:0] a_oreg;
    logic                        a_stall, a_busy, a_rdbusy, a_valid, a_done, a_err;
    logic [memarb_pkg::REGW-1:0] a_wreg;
    logic [DW-1:0]               a_result;
    // Requester B
    logic                        b_stb, b_lock;
    logic [2:0]                  b_op;
    logic [AW-1:0]               b_addr;
    logic [DW-1:0]               b_data;
    logic [memarb_pkg::REGW-1:0] b_oreg;
    logic                        b_stall, b_busy, b_rdbusy, b_valid, b_done, b_err;
    logic [memarb_pkg::REGW-1:0] b_wreg;
    logic [DW-1:0]               b_result;
    // Memory unit
    logic                        m_stb, m_lock;
    logic [2:0]                  m_op;
    logic [AW-1:0]               m_addr;
    logic [DW-1:0]               m_data;
    logic [memarb_pkg::REGW-1:0] m_oreg;
    logic                        m_busy, m_rdbusy, m_valid, m_done, m_err;
    logic [memarb_pkg::REGW-1:0] m_wreg;
    logic [DW-1:0]               m_result;

    // Arbiter view
    modport slave (
        input  a_stb, a_lock, a_op, a_addr, a_data, a_oreg,
        output a_stall, a_busy, a_rdbusy, a_valid, a_done, a_err, a_wreg, a_result,
        input  b_stb, b_lock, b_op, b_addr, b_data, b_oreg,
        output b_stall, b_busy, b_rdbusy, b_valid, b_done, b_err, b_wreg, b_result,
        output m_stb, m_lock, m_op, m_addr, m_data, m_oreg,
        input  m_busy, m_rdbusy, m_valid, m_done, m_err, m_wreg, m_result
    );

    // Environment view (requesters plus memory unit)
    modport master (
        output a_stb, a_lock, a_op, a_addr, a_data, a_oreg,
        input  a_stall, a_busy, a_rdbusy, a_valid, a_done, a_err, a_wreg, a_result,
        output b_stb, b_lock, b_op, b_addr, b_data, b_oreg,
        input  b_stall, b_busy, b_rdbusy, b_valid, b_done, b_err, b_wreg, b_result,
        input  m_stb, m_lock, m_op, m_addr, m_data, m_oreg,
        output m_busy, m_rdbusy, m_valid, m_done, m_err, m_wreg, m_result
    );

endinterface

`default_nettype wire

// File: rtl/memarb_pick.sv
// ============================================================================
// memarb_pick : combinational requester selection from IDLE
// Optional MEMARB_ROUND_ROBIN_EN: ties go to the requester not served last.
// Rev 1.0
// ============================================================================
`default_nettype none

module memarb_pick
    import memarb_pkg::*;
(
    output grant_t pick,
    input  logic   stb_a,
    input  logic   stb_b
`ifdef MEMARB_ROUND_ROBIN_EN
    ,
    input  logic   last_b
`endif
);

    always_comb begin
        pick = IDLE;
        if (stb_a && stb_b) begin
`ifdef MEMARB_ROUND_ROBIN_EN
            pick = last_b ? OWN_A : OWN_B;
`else
            pick = OWN_A;
`endif
        end else if (stb_a) begin
            pick = OWN_A;
        end else if (stb_b) begin
            pick = OWN_B;
        end
    end

endmodule

`default_nettype wire

// File: rtl/memop_arbiter.sv
// ============================================================================
// memop_arbiter : shares one memory-op unit between requesters A and B
// Optional MEMARB_ROUND_ROBIN_EN selects round-robin tie-break (else A wins).
// Rev 1.0
// ============================================================================
`default_nettype none

module memop_arbiter
    import memarb_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int F_LGDEPTH    = 4,
    parameter int OPT_MAXDEPTH = 1
)(
    input  logic           i_clk,
    input  logic           i_reset_n,
    memop_arbiter_if.slave bus
);

    localparam logic [F_LGDEPTH-1:0] MAXD = F_LGDEPTH'(OPT_MAXDEPTH);

    grant_t               grant, grant_nxt, pick;
    logic                 err_q, lock_held;
    logic [F_LGDEPTH-1:0] outstanding, outstanding_nxt;
    logic                 own_a, own_b, owner_stb, owner_lock, accept, blocked, release_ok;

    assign own_a   = (grant == OWN_A);
    assign own_b   = (grant == OWN_B);
    assign blocked = bus.m_busy | bus.m_err | err_q;
    assign accept  = owner_stb & ~blocked & (outstanding < MAXD);

`ifdef MEMARB_ROUND_ROBIN_EN
    logic last_b;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            last_b <= 1'b1;
        else if (grant == IDLE && pick != IDLE)
            last_b <= (pick == OWN_B);
    end

    memarb_pick u_pick (
        .pick   (pick),
        .stb_a  (bus.a_stb),
        .stb_b  (bus.b_stb),
        .last_b (last_b)
    );
`else
    memarb_pick u_pick (
        .pick   (pick),
        .stb_a  (bus.a_stb),
        .stb_b  (bus.b_stb)
    );
`endif

    // Request mux toward the memory unit; all zero while IDLE
    always_comb begin
        owner_stb  = 1'b0;
        owner_lock = 1'b0;
        bus.m_op   = 3'b000;
        bus.m_addr = {AW{1'b0}};
        bus.m_data = {DW{1'b0}};
        bus.m_oreg = '0;
        if (own_a) begin
            owner_stb  = bus.a_stb;
            owner_lock = bus.a_lock;
            bus.m_op   = bus.a_op;
            bus.m_addr = bus.a_addr;
            bus.m_data = bus.a_data;
            bus.m_oreg = bus.a_oreg;
        end else if (own_b) begin
            owner_stb  = bus.b_stb;
            owner_lock = bus.b_lock;
            bus.m_op   = bus.b_op;
            bus.m_addr = bus.b_addr;
            bus.m_data = bus.b_data;
            bus.m_oreg = bus.b_oreg;
        end
        bus.m_stb  = accept;
        bus.m_lock = owner_lock;
    end

    // Response routing: only the current owner sees the unit
    always_comb begin
        bus.a_stall  = ~own_a | blocked | (outstanding == MAXD);
        bus.b_stall  = ~own_b | blocked | (outstanding == MAXD);
        bus.a_busy   = own_a & bus.m_busy;
        bus.a_rdbusy = own_a & bus.m_rdbusy;
        bus.a_valid  = own_a & bus.m_valid;
        bus.a_done   = own_a & bus.m_done;
        bus.a_err    = own_a & bus.m_err;
        bus.a_wreg   = own_a ? bus.m_wreg : '0;
        bus.a_result = own_a ? bus.m_result : {DW{1'b0}};
        bus.b_busy   = own_b & bus.m_busy;
        bus.b_rdbusy = own_b & bus.m_rdbusy;
        bus.b_valid  = own_b & bus.m_valid;
        bus.b_done   = own_b & bus.m_done;
        bus.b_err    = own_b & bus.m_err;
        bus.b_wreg   = own_b ? bus.m_wreg : '0;
        bus.b_result = own_b ? bus.m_result : {DW{1'b0}};
    end

    assign release_ok = (outstanding == '0) & ~bus.m_busy & ~lock_held & ~owner_stb;

    always_comb begin
        grant_nxt = grant;
        case (grant)
            IDLE:         grant_nxt = pick;
            OWN_A, OWN_B: if (release_ok) grant_nxt = IDLE;
            default:      grant_nxt = IDLE;
        endcase
    end

    // Counter saturates at both ends so a stray done can never wrap it
    always_comb begin
        outstanding_nxt = outstanding;
        if (bus.m_err)
            outstanding_nxt = '0;
        else if (accept && !bus.m_done && outstanding < MAXD)
            outstanding_nxt = outstanding + 1'b1;
        else if (!accept && bus.m_done && outstanding != '0)
            outstanding_nxt = outstanding - 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            grant       <= IDLE;
            outstanding <= '0;
            err_q       <= 1'b0;
            lock_held   <= 1'b0;
        end else begin
            grant       <= grant_nxt;
            outstanding <= outstanding_nxt;
            err_q       <= bus.m_err;
            if (bus.m_err)
                lock_held <= 1'b0;
            else if (accept)
                lock_held <= owner_lock;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memop_arbiter.sv
// ============================================================================
// tb_memop_arbiter : directed table-driven bench for memop_arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_memop_arbiter;
    import memarb_pkg::*;

    localparam logic [31:0] RES    = 32'hDEADBEEF;
    localparam logic [31:0] A_ADDR = 32'h0000_0100;
    localparam logic [31:0] B_ADDR = 32'h0000_0010;
`ifdef MEMARB_ROUND_ROBIN_EN
    localparam logic [1:0] T2 = 2'd2;
`else
    localparam logic [1:0] T2 = 2'd1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    memop_arbiter_if #(.AW(32), .DW(32)) bus1 ();
    memop_arbiter_if #(.AW(32), .DW(32)) bus2 ();

    memop_arbiter #(.AW(32), .DW(32), .F_LGDEPTH(4), .OPT_MAXDEPTH(1)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bus1.slave));
    memop_arbiter #(.AW(32), .DW(32), .F_LGDEPTH(4), .OPT_MAXDEPTH(2)) dut2 (
        .i_clk(clk), .i_reset_n(rst_n), .bus(bus2.slave));

    // in = {a_stb, a_lock, b_stb, b_lock, m_busy, m_done, m_err}
    // eo = {m_stb, a_stall, b_stall}; g/o/l = grant, outstanding, lock_held
    typedef struct {
        string      name;
        logic [6:0] in;
        logic [2:0] eo;
        logic [1:0] g;
        logic [3:0] o;
        logic       l;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string n, input logic [6:0] in, input logic [2:0] eo,
                       input logic [1:0] g, input logic [3:0] o, input logic l);
        vec_t v;
        v.name = n; v.in = in; v.eo = eo; v.g = g; v.o = o; v.l = l;
        vq.push_back(v);
    endtask

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic [6:0] in);
        bus1.a_stb    = in[6];
        bus1.a_lock   = in[5];
        bus1.b_stb    = in[4];
        bus1.b_lock   = in[3];
        bus1.m_busy   = in[2];
        bus1.m_rdbusy = in[2];
        bus1.m_done   = in[1];
        bus1.m_valid  = in[1];
        bus1.m_err    = in[0];
    endtask

    initial begin
        logic [1:0] g;
        logic [6:0] in;

        drive1(7'b0);
        bus1.a_op = 3'b100; bus1.a_addr = A_ADDR; bus1.a_data = 32'h0;  bus1.a_oreg = 5'd3;
        bus1.b_op = 3'b011; bus1.b_addr = B_ADDR; bus1.b_data = 32'h55; bus1.b_oreg = 5'd9;
        bus1.m_wreg = 5'd7; bus1.m_result = RES;
        bus2.a_stb = 1'b0; bus2.a_lock = 1'b0; bus2.b_stb = 1'b0; bus2.b_lock = 1'b0;
        bus2.a_op = 3'b100; bus2.a_addr = A_ADDR; bus2.a_data = 32'h0; bus2.a_oreg = 5'd1;
        bus2.b_op = 3'b100; bus2.b_addr = B_ADDR; bus2.b_data = 32'h0; bus2.b_oreg = 5'd2;
        bus2.m_busy = 1'b0; bus2.m_rdbusy = 1'b0; bus2.m_valid = 1'b0; bus2.m_done = 1'b0;
        bus2.m_err = 1'b0; bus2.m_wreg = 5'd0; bus2.m_result = RES;

        // Reset state
        #3;
        chk("rst.m_stb",   bus1.m_stb,   0);
        chk("rst.a_stall", bus1.a_stall, 1);
        chk("rst.b_stall", bus1.b_stall, 1);
        chk("rst.a_result", bus1.a_result, 0);
        chk("rst.grant",   dut1.grant,   0);
        tick();
        rst_n = 1'b1;

        // 1: A-only load
        add("t1_pick",  7'b1000000, 3'b011, 2'd0, 0, 0);
        add("t1_acc",   7'b1000000, 3'b101, 2'd1, 0, 0);
        add("t1_busy",  7'b0000100, 3'b011, 2'd1, 1, 0);
        add("t1_done",  7'b0000010, 3'b011, 2'd1, 1, 0);
        add("t1_rel",   7'b0000000, 3'b001, 2'd1, 0, 0);
        add("t1_idle",  7'b0000000, 3'b011, 2'd0, 0, 0);
        // 2: ties from IDLE
        add("t2_tie",   7'b1010000, 3'b011, 2'd0, 0, 0);
        add("t2_acc",   7'b1010000, 3'b101, 2'd1, 0, 0);
        add("t2_done",  7'b0010010, 3'b011, 2'd1, 1, 0);
        add("t2_rel",   7'b0010000, 3'b001, 2'd1, 0, 0);
        add("t2_tie2",  7'b1010000, 3'b011, 2'd0, 0, 0);
        add("t2_acc2",  7'b1010000, (T2 == 2'd1) ? 3'b101 : 3'b110, T2, 0, 0);
        add("t2_done2", 7'b0000010, 3'b011, T2, 1, 0);
        add("t2_rel2",  7'b0000000, (T2 == 2'd1) ? 3'b001 : 3'b010, T2, 0, 0);
        add("t2_idle",  7'b0000000, 3'b011, 2'd0, 0, 0);
        // 3: B locked sequence while A keeps requesting
        add("t3_pick",  7'b0011000, 3'b011, 2'd0, 0, 0);
        add("t3_acc1",  7'b1011000, 3'b110, 2'd2, 0, 0);
        add("t3_done1", 7'b1000010, 3'b011, 2'd2, 1, 1);
        add("t3_hold",  7'b1000000, 3'b010, 2'd2, 0, 1);
        add("t3_acc2",  7'b1011000, 3'b110, 2'd2, 0, 1);
        add("t3_done2", 7'b1011010, 3'b011, 2'd2, 1, 1);
        add("t3_acc3",  7'b1010000, 3'b110, 2'd2, 0, 1);
        add("t3_done3", 7'b1000010, 3'b011, 2'd2, 1, 0);
        add("t3_rel",   7'b1000000, 3'b010, 2'd2, 0, 0);
        add("t3_pickA", 7'b1000000, 3'b011, 2'd0, 0, 0);
        add("t3_accA",  7'b1000000, 3'b101, 2'd1, 0, 0);
        add("t3_doneA", 7'b0000010, 3'b011, 2'd1, 1, 0);
        add("t3_relA",  7'b0000000, 3'b001, 2'd1, 0, 0);
        add("t3_idle",  7'b0000000, 3'b011, 2'd0, 0, 0);
        // 4: error on A's op
        add("t4_pick",  7'b1100000, 3'b011, 2'd0, 0, 0);
        add("t4_acc",   7'b1100000, 3'b101, 2'd1, 0, 0);
        add("t4_err",   7'b1100001, 3'b011, 2'd1, 1, 1);
        add("t4_errq",  7'b1000000, 3'b011, 2'd1, 0, 0);
        add("t4_acc2",  7'b1000000, 3'b101, 2'd1, 0, 0);
        add("t4_done",  7'b0000010, 3'b011, 2'd1, 1, 0);
        add("t4_rel",   7'b0000000, 3'b001, 2'd1, 0, 0);
        add("t4_idle",  7'b0000000, 3'b011, 2'd0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            in = vq[i].in;
            g  = vq[i].g;
            drive1(in);
            #2;
            chk({vq[i].name, ".m_stb"},   bus1.m_stb,   vq[i].eo[2]);
            chk({vq[i].name, ".a_stall"}, bus1.a_stall, vq[i].eo[1]);
            chk({vq[i].name, ".b_stall"}, bus1.b_stall, vq[i].eo[0]);
            chk({vq[i].name, ".grant"},   dut1.grant,   g);
            chk({vq[i].name, ".outst"},   dut1.outstanding, vq[i].o);
            chk({vq[i].name, ".lock"},    dut1.lock_held,   vq[i].l);
            chk({vq[i].name, ".a_done"},  bus1.a_done,  (g == 2'd1) & in[1]);
            chk({vq[i].name, ".b_done"},  bus1.b_done,  (g == 2'd2) & in[1]);
            chk({vq[i].name, ".a_valid"}, bus1.a_valid, (g == 2'd1) & in[1]);
            chk({vq[i].name, ".a_err"},   bus1.a_err,   (g == 2'd1) & in[0]);
            chk({vq[i].name, ".b_err"},   bus1.b_err,   (g == 2'd2) & in[0]);
            chk({vq[i].name, ".a_busy"},  bus1.a_busy,  (g == 2'd1) & in[2]);
            chk({vq[i].name, ".b_rdbusy"}, bus1.b_rdbusy, (g == 2'd2) & in[2]);
            chk({vq[i].name, ".a_result"}, bus1.a_result, (g == 2'd1) ? RES : 32'h0);
            chk({vq[i].name, ".b_result"}, bus1.b_result, (g == 2'd2) ? RES : 32'h0);
            chk({vq[i].name, ".a_wreg"},  bus1.a_wreg,  (g == 2'd1) ? 5'd7 : 5'd0);
            chk({vq[i].name, ".m_addr"},  bus1.m_addr,
                (g == 2'd1) ? A_ADDR : (g == 2'd2) ? B_ADDR : 32'h0);
            chk({vq[i].name, ".m_lock"},  bus1.m_lock,
                (g == 2'd1) ? in[5] : (g == 2'd2) ? in[3] : 1'b0);
            tick();
        end
        drive1(7'b0);

        // 5: depth-2 instance, three back-to-back loads from A
        bus2.a_stb = 1'b1;
        #2; chk("t5_pick.m_stb", bus2.m_stb, 0);
        tick();
        #2; chk("t5_acc1.m_stb", bus2.m_stb, 1);
        tick();
        #2; chk("t5_acc2.m_stb", bus2.m_stb, 1); chk("t5_acc2.a_stall", bus2.a_stall, 0);
            chk("t5_acc2.outst", dut2.outstanding, 1);
        tick();
        #2; chk("t5_full.m_stb", bus2.m_stb, 0); chk("t5_full.a_stall", bus2.a_stall, 1);
            chk("t5_full.outst", dut2.outstanding, 2);
        tick();
        bus2.m_done = 1'b1; bus2.m_valid = 1'b1;
        #2; chk("t5_done1.m_stb", bus2.m_stb, 0); chk("t5_done1.a_done", bus2.a_done, 1);
        tick();
        bus2.m_done = 1'b0; bus2.m_valid = 1'b0;
        #2; chk("t5_acc3.m_stb", bus2.m_stb, 1); chk("t5_acc3.outst", dut2.outstanding, 1);
        tick();
        bus2.a_stb = 1'b0; bus2.m_done = 1'b1;
        #2; chk("t5_peak.outst", dut2.outstanding, 2);
        tick();
        #2; chk("t5_drain.outst", dut2.outstanding, 1);
        tick();
        bus2.m_done = 1'b0;
        #2; chk("t5_empty.outst", dut2.outstanding, 0);
        tick();
        #2; chk("t5_idle.grant", dut2.grant, 0);
        tick();

        // 6: asynchronous reset with one op in flight
        drive1(7'b1000000);
        tick();
        tick();
        drive1(7'b0000100);
        #2; chk("t6_inflight.outst", dut1.outstanding, 1);
        rst_n = 1'b0;
        #1;
        chk("t6_rst.m_stb",   bus1.m_stb,   0);
        chk("t6_rst.a_stall", bus1.a_stall, 1);
        chk("t6_rst.b_stall", bus1.b_stall, 1);
        chk("t6_rst.a_busy",  bus1.a_busy,  0);
        chk("t6_rst.grant",   dut1.grant,   0);
        chk("t6_rst.outst",   dut1.outstanding, 0);
        tick();
        rst_n = 1'b1;
        drive1(7'b0000010);
        #2;
        chk("t6_stray.a_done",   bus1.a_done,   0);
        chk("t6_stray.a_valid",  bus1.a_valid,  0);
        chk("t6_stray.b_done",   bus1.b_done,   0);
        chk("t6_stray.a_result", bus1.a_result, 0);
        chk("t6_stray.outst",    dut1.outstanding, 0);
        tick();
        drive1(7'b0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
